// File: rtl/core_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: FSM states and the
// per-stage control word that drives pipeline register enables and NOP inserts.
package core_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HzRun     = 2'd0,
    HzMemWait = 2'd1,
    HzExBusy  = 2'd2,
    HzFlush   = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic if_en;
    logic id_en;
    logic ex_en;
    logic mem_en;
    logic id_flush;
    logic ex_flush;
    logic mem_bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t CtrlGo        = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CtrlHold      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CtrlNop       = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam stage_ctrl_t CtrlExBusy    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam stage_ctrl_t CtrlJump      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam stage_ctrl_t CtrlLoadUse   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam stage_ctrl_t CtrlTimeout   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam stage_ctrl_t CtrlFlushHold = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/core_hazard_ctrl.sv
// Execute-stage pipeline sequencer: merges load-use hazards, EX busy requests, taken
// jumps and the data-memory handshake into stage enables and flush/bubble controls.
module core_hazard_ctrl
  import core_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGF_AW     = 5,
  parameter int unsigned FLUSH_CYC   = 2,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [REGF_AW-1:0] i_ID_Rs1,
  input  logic [REGF_AW-1:0] i_ID_Rs2,
  input  logic               i_ID_UseRs1,
  input  logic               i_ID_UseRs2,
  input  logic [REGF_AW-1:0] i_EX_RegFAddr,
  input  logic               i_EX_IsLoad,
  input  logic               i_EX_StallEn,
  input  logic               i_EX_JumpEn,
  input  logic               i_Mem_Req,
  input  logic               i_Mem_Ack,
  output logic               o_IF_En,
  output logic               o_ID_En,
  output logic               o_EX_En,
  output logic               o_MEM_En,
  output logic               o_ID_Flush,
  output logic               o_EX_Flush,
  output logic               o_MEM_Bubble,
  output logic [1:0]         o_State,
  output logic               o_Event,
  output logic [CNT_W-1:0]   o_StallCnt
);

  localparam int unsigned WaitW  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned FlushW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [WaitW-1:0]  WaitOne   = WaitW'(1);
  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(MEM_TIMEOUT - 1);
  localparam logic [FlushW-1:0] FlushOne  = FlushW'(1);
  localparam logic [FlushW-1:0] FlushInit = FlushW'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);

  function automatic logic load_use(input logic [REGF_AW-1:0] rs1,
                                    input logic [REGF_AW-1:0] rs2,
                                    input logic use1, input logic use2,
                                    input logic [REGF_AW-1:0] rd, input logic is_load);
    return is_load && (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

  hz_state_e         state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [FlushW-1:0] flush_q, flush_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              event_q, event_d;

  stage_ctrl_t ctrl, res_ctrl;
  hz_state_e   res_state;
  logic        mem_stall, lu_hazard;

  assign mem_stall = i_Mem_Req & ~i_Mem_Ack;
  assign lu_hazard = load_use(i_ID_Rs1, i_ID_Rs2, i_ID_UseRs1, i_ID_UseRs2,
                              i_EX_RegFAddr, i_EX_IsLoad);

  // Non-memory resolution shared by RUN, EXBUSY and the MEMWAIT ack cycle.
  always_comb begin
    res_ctrl  = CtrlGo;
    res_state = HzRun;
    if (i_EX_StallEn) begin
      res_ctrl  = CtrlExBusy;
      res_state = HzExBusy;
    end else if (i_EX_JumpEn) begin
      res_ctrl  = CtrlJump;
      res_state = (FLUSH_CYC > 1) ? HzFlush : HzRun;
    end else if (lu_hazard) begin
      res_ctrl = CtrlLoadUse;
    end
  end

  always_comb begin
    ctrl    = CtrlGo;
    state_d = state_q;
    wait_d  = wait_q;
    flush_d = flush_q;
    event_d = 1'b0;
    unique case (state_q)
      HzRun, HzExBusy: begin
        if (mem_stall) begin
          ctrl    = CtrlHold;
          state_d = HzMemWait;
          wait_d  = WaitOne;
        end else begin
          ctrl    = res_ctrl;
          state_d = res_state;
          if (res_state == HzFlush) flush_d = FlushInit;
        end
      end
      HzMemWait: begin
        if (i_Mem_Ack) begin
          ctrl    = res_ctrl;
          state_d = res_state;
          if (res_state == HzFlush) flush_d = FlushInit;
        end else if (wait_q == WaitLast) begin
          ctrl    = CtrlTimeout;
          state_d = HzRun;
          event_d = 1'b1;
        end else begin
          ctrl   = CtrlHold;
          wait_d = wait_q + WaitOne;
        end
      end
      HzFlush: begin
        // EX holds a NOP here, so jump/stall/load-use inputs are meaningless.
        if (mem_stall) begin
          ctrl = CtrlFlushHold;
        end else begin
          ctrl    = CtrlJump;
          flush_d = flush_q - FlushOne;
          if (flush_q == FlushOne) state_d = HzRun;
        end
      end
      default: state_d = HzRun;
    endcase
    if (i_Rst) ctrl = CtrlNop;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= HzRun;
      wait_q      <= '0;
      flush_q     <= '0;
      event_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
      event_q <= event_d;
      if (!ctrl.if_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CntOne;
    end
  end

  assign o_IF_En      = ctrl.if_en;
  assign o_ID_En      = ctrl.id_en;
  assign o_EX_En      = ctrl.ex_en;
  assign o_MEM_En     = ctrl.mem_en;
  assign o_ID_Flush   = ctrl.id_flush;
  assign o_EX_Flush   = ctrl.ex_flush;
  assign o_MEM_Bubble = ctrl.mem_bubble;
  assign o_State      = state_q;
  assign o_Event      = event_q;
  assign o_StallCnt   = stall_cnt_q;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed bench for core_hazard_ctrl: per-scenario tasks with hand-computed
// control words ordered {IF_En, ID_En, EX_En, MEM_En, ID_Flush, EX_Flush, MEM_Bubble}.
module tb_core_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       use_rs1 = 1'b0, use_rs2 = 1'b0, ex_load = 1'b0;
  logic       ex_stall = 1'b0, ex_jump = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic       if_en, id_en, ex_en, mem_en, id_flush, ex_flush, mem_bubble, ev;
  logic [1:0] state;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  core_hazard_ctrl #(
    .REGF_AW    (5),
    .FLUSH_CYC  (2),
    .MEM_TIMEOUT(4),
    .CNT_W      (16)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_ID_Rs1     (id_rs1),
    .i_ID_Rs2     (id_rs2),
    .i_ID_UseRs1  (use_rs1),
    .i_ID_UseRs2  (use_rs2),
    .i_EX_RegFAddr(ex_rd),
    .i_EX_IsLoad  (ex_load),
    .i_EX_StallEn (ex_stall),
    .i_EX_JumpEn  (ex_jump),
    .i_Mem_Req    (mem_req),
    .i_Mem_Ack    (mem_ack),
    .o_IF_En      (if_en),
    .o_ID_En      (id_en),
    .o_EX_En      (ex_en),
    .o_MEM_En     (mem_en),
    .o_ID_Flush   (id_flush),
    .o_EX_Flush   (ex_flush),
    .o_MEM_Bubble (mem_bubble),
    .o_State      (state),
    .o_Event      (ev),
    .o_StallCnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {if_en, id_en, ex_en, mem_en, id_flush, ex_flush, mem_bubble};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ctl() !== 7'b0000111) begin errors++;
      $display("FAIL reset_ctrl: got %b want %b", ctl(), 7'b0000111); end
    checks++; if (state !== 2'd0) begin errors++;
      $display("FAIL reset_state: got %0d want 0", state); end
    tick();
    checks++; if (stall_cnt !== 16'd0 || ev !== 1'b0) begin errors++;
      $display("FAIL reset_regs: got cnt=%0d ev=%b want 0/0", stall_cnt, ev); end
    rst = 1'b0;
    #1;
    checks++; if (ctl() !== 7'b1111000) begin errors++;
      $display("FAIL idle_ctrl: got %b want %b", ctl(), 7'b1111000); end
  endtask

  task automatic test_load_use();
    tick();
    ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1; #1;
    checks++; if (ctl() !== 7'b0011010) begin errors++;
      $display("FAIL lu_rs1: got %b want %b", ctl(), 7'b0011010); end
    tick(); exp_cnt++;
    ex_load = 1'b0; #1;
    checks++; if (ctl() !== 7'b1111000 || state !== 2'd0) begin errors++;
      $display("FAIL lu_resolve: got %b st=%0d want %b st=0", ctl(), state, 7'b1111000); end
    ex_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    checks++; if (ctl() !== 7'b1111000) begin errors++;
      $display("FAIL lu_x0: got %b want %b", ctl(), 7'b1111000); end
    ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; use_rs2 = 1'b0; #1;
    checks++; if (ctl() !== 7'b1111000) begin errors++;
      $display("FAIL lu_rs2_unused: got %b want %b", ctl(), 7'b1111000); end
    use_rs2 = 1'b1; #1;
    checks++; if (ctl() !== 7'b0011010) begin errors++;
      $display("FAIL lu_rs2: got %b want %b", ctl(), 7'b0011010); end
    tick(); exp_cnt++;
    ex_load = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; #1;
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++;
      $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_mem_wait();
    tick();
    mem_req = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctl() !== 7'b0000000 || state !== 2'(i > 0 ? 1 : 0)) begin errors++;
        $display("FAIL memwait_%0d: got %b st=%0d want 0000000", i, ctl(), state); end
      tick(); exp_cnt++;
    end
    mem_ack = 1'b1; #1;
    checks++; if (ctl() !== 7'b1111000 || state !== 2'd1) begin errors++;
      $display("FAIL mem_ack: got %b st=%0d want 1111000 st=1", ctl(), state); end
    tick();
    mem_req = 1'b0; mem_ack = 1'b0; #1;
    checks++; if (state !== 2'd0 || stall_cnt !== 16'(exp_cnt)) begin errors++;
      $display("FAIL mem_exit: got st=%0d cnt=%0d want 0/%0d", state, stall_cnt, exp_cnt); end
  endtask

  task automatic test_ex_busy();
    ex_stall = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctl() !== 7'b0001001 || state !== 2'(i > 0 ? 2 : 0)) begin errors++;
        $display("FAIL exbusy_%0d: got %b st=%0d want 0001001", i, ctl(), state); end
      tick(); exp_cnt++;
    end
    ex_stall = 1'b0; ex_jump = 1'b1; #1;
    checks++; if (ctl() !== 7'b1111110 || state !== 2'd2) begin errors++;
      $display("FAIL exbusy_jump: got %b st=%0d want 1111110 st=2", ctl(), state); end
    tick();
    ex_jump = 1'b0; #1;
    checks++; if (ctl() !== 7'b1111110 || state !== 2'd3) begin errors++;
      $display("FAIL exbusy_flush: got %b st=%0d want 1111110 st=3", ctl(), state); end
    tick();
    checks++; if (ctl() !== 7'b1111000 || state !== 2'd0 || stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL exbusy_exit: got %b st=%0d cnt=%0d want 1111000 0 %0d",
               ctl(), state, stall_cnt, exp_cnt); end
  endtask

  task automatic test_flush_mem();
    ex_jump = 1'b1; #1;
    checks++; if (ctl() !== 7'b1111110) begin errors++;
      $display("FAIL jump: got %b want %b", ctl(), 7'b1111110); end
    tick();
    ex_jump = 1'b0; mem_req = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ctl() !== 7'b0000110 || state !== 2'd3) begin errors++;
        $display("FAIL flush_hold_%0d: got %b st=%0d want 0000110 st=3", i, ctl(), state); end
      tick(); exp_cnt++;
    end
    mem_ack = 1'b1; ex_stall = 1'b1; #1;
    checks++; if (ctl() !== 7'b1111110 || state !== 2'd3) begin errors++;
      $display("FAIL flush_resume: got %b st=%0d want 1111110 st=3", ctl(), state); end
    tick();
    mem_req = 1'b0; mem_ack = 1'b0; ex_stall = 1'b0; #1;
    checks++; if (ctl() !== 7'b1111000 || state !== 2'd0 || stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL flush_exit: got %b st=%0d cnt=%0d want 1111000 0 %0d",
               ctl(), state, stall_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    mem_req = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctl() !== 7'b0000000 || ev !== 1'b0) begin errors++;
        $display("FAIL tmo_wait_%0d: got %b ev=%b want 0000000 ev=0", i, ctl(), ev); end
      tick(); exp_cnt++;
    end
    checks++; if (ctl() !== 7'b1111001 || state !== 2'd1) begin errors++;
      $display("FAIL tmo_abort: got %b st=%0d want 1111001 st=1", ctl(), state); end
    tick();
    mem_req = 1'b0; #1;
    checks++; if (ev !== 1'b1 || state !== 2'd0 || ctl() !== 7'b1111000) begin errors++;
      $display("FAIL tmo_event: got ev=%b st=%0d %b want 1 0 1111000", ev, state, ctl()); end
    tick();
    checks++; if (ev !== 1'b0 || stall_cnt !== 16'(exp_cnt)) begin errors++;
      $display("FAIL tmo_pulse: got ev=%b cnt=%0d want 0 %0d", ev, stall_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    ex_stall = 1'b1; #1;
    tick(); exp_cnt++;
    mem_req = 1'b1; #1;
    checks++; if (ctl() !== 7'b0000000 || state !== 2'd2) begin errors++;
      $display("FAIL b2b_memstall: got %b st=%0d want 0000000 st=2", ctl(), state); end
    tick(); exp_cnt++;
    mem_ack = 1'b1; #1;
    checks++; if (ctl() !== 7'b0001001 || state !== 2'd1) begin errors++;
      $display("FAIL b2b_ack_busy: got %b st=%0d want 0001001 st=1", ctl(), state); end
    tick(); exp_cnt++;
    mem_req = 1'b0; mem_ack = 1'b0; ex_stall = 1'b0; #1;
    checks++; if (ctl() !== 7'b1111000) begin errors++;
      $display("FAIL b2b_release: got %b want %b", ctl(), 7'b1111000); end
    tick();
    checks++; if (state !== 2'd0 || stall_cnt !== 16'(exp_cnt)) begin errors++;
      $display("FAIL b2b_cnt: got st=%0d cnt=%0d want 0 %0d", state, stall_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset();
    mem_req = 1'b1; #1;
    tick();
    checks++; if (state !== 2'd1) begin errors++;
      $display("FAIL ar_memwait: got st=%0d want 1", state); end
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    checks++; if (state !== 2'd0 || stall_cnt !== 16'd0 || ctl() !== 7'b0000111) begin errors++;
      $display("FAIL ar_immediate: got st=%0d cnt=%0d %b want 0 0 0000111",
               state, stall_cnt, ctl()); end
    tick();
    mem_req = 1'b0; rst = 1'b0; #1;
    checks++; if (ctl() !== 7'b1111000 || state !== 2'd0 || stall_cnt !== 16'd0) begin errors++;
      $display("FAIL ar_release: got %b st=%0d cnt=%0d want 1111000 0 0",
               ctl(), state, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_ex_busy();
    test_flush_mem();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
